branch_resolver: RTL and testbench
==================================

# branch_resolver

Resolution-side companion to the 2-bit branch predictor. Queues each prediction issued at fetch until the execute stage reports the real outcome, then compares the two. It drives the predictor's `taken` update input, flags mispredictions and flushes younger in-flight predictions. It also holds fetch off for a fixed recovery window after each flush.

## Interface
- `DEPTH`, 4: in-flight prediction queue entries; power of two, ≥2.
- `RECOVER_CYC`, 3: cycles fetch is stalled after a mispredict; ≥1.
- `CNT_W`, 8: width of the statistics counters.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `pred_valid`  in  1  fetch issues a prediction this cycle.
- `pred_taken`  in  1  predicted direction (predictor `predict` output).
- `pred_ready`  out  1  queue accepts a prediction.
- `res_valid`  in  1  execute resolves the oldest branch this cycle.
- `res_taken`  in  1  actual direction.
- `upd_valid`  out  1  one-cycle strobe: apply `upd_taken` to predictor.
- `upd_taken`  out  1  actual direction forwarded to predictor `taken`.
- `mispredict`  out  1  one-cycle pulse, prediction ≠ outcome.
- `underflow`  out  1  sticky: resolution arrived with queue empty.
- `pending`  out  $clog2(DEPTH)+1  current queue occupancy.
- `branch_cnt`  out  CNT_W  resolved branches, saturating.
- `miss_cnt`  out  CNT_W  mispredictions, saturating.

## Operation
- Queue: circular buffer of 1-bit predictions, write/read pointers `$clog2(DEPTH)` bits wide, wrap modulo DEPTH. Occupancy counter 0..DEPTH.
- Push: `pred_valid & pred_ready`. Pop: `res_valid & pending!=0`.
- `res_valid` with `pending==0`: no pop, no update, no mispredict. `underflow` sets and stays set until reset.
- On pop: `upd_valid`=1 and `upd_taken`=`res_taken` next cycle. `mispredict`=1 next cycle if popped entry ≠ `res_taken`.
- Mispredict flush: in the pop cycle, pointers and occupancy clear to 0. A same-cycle push is discarded because it is younger.
- Simultaneous push and pop without mispredict: occupancy unchanged, both pointers advance.
- FSM with two states:
  - RUN: `pred_ready` = (pending<DEPTH). A mispredicting pop goes to RECOVER and loads the recovery counter with RECOVER_CYC-1.
  - RECOVER: `pred_ready`=0. Pops are still processed and the queue is empty anyway. `res_valid` therefore sets `underflow`. The counter decrements each cycle and the FSM returns to RUN when it reaches 0.
- Counters: `branch_cnt` increments on every pop and `miss_cnt` on every mispredicting pop. Both saturate at 2^CNT_W-1.

## Timing
- Reset (async assert, sync release in surrounding logic): state RUN, pointers/occupancy 0, `pred_ready`=1, `upd_valid`=0, `upd_taken`=0, `mispredict`=0, `underflow`=0, `pending`=0, counters 0.
- `pred_ready` is combinational from state/occupancy only, never from `pred_valid` or `res_valid`.
- `upd_valid`, `upd_taken`, `mispredict` are registered, with one cycle latency from the pop edge. Each is high for exactly one cycle per pop.
- `pending` and the counters reflect the edge they update on.
- RECOVER lasts exactly RECOVER_CYC cycles. `pred_ready` rises on the cycle after the last RECOVER cycle.
- Full queue in RUN: `pred_ready`=0. A simultaneous pop does not re-enable it in the same cycle.
- Reset mid-operation: all in-flight entries are lost and the state is as above, immediately on `reset`=0.

## Configuration
- `BRANCH_RESOLVER_STATS_EN`:
  - Defined: `branch_cnt`/`miss_cnt` counters are implemented as above.
  - Undefined: no counter flops; both ports tie to 0. All other behaviour is identical.

## Test plan
- Reset, push T,T,N (pending=3), resolve T,T,N → three `upd_valid` strobes with `upd_taken`=1,1,0, `mispredict` never high, pending=0, branch_cnt=3, miss_cnt=0.
- Push 4 predictions with DEPTH=4 → `pred_ready`=0 at pending=4. A 5th `pred_valid` is ignored. Pop one, then the next cycle `pred_ready`=1.
- Push T,T,T, resolve first with N → `mispredict` pulse 1 cycle later, pending=0, `pred_ready`=0 for exactly 3 cycles, miss_cnt=1.
- Same cycle as a mispredicting pop, assert `pred_valid` → that push is dropped and pending=0 afterwards.
- `res_valid` with empty queue → `underflow`=1 and stays 1, no `upd_valid`. Then assert `reset`=0 → `underflow`=0.
- With stats enabled, CNT_W=2, resolve 5 mispredicting branches (re-pushing after each recovery) → miss_cnt saturates at 3 and branch_cnt saturates at 3.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch resolver: queues fetch-time predictions, compares them with execute outcomes,
// drives predictor updates and flushes/stalls fetch on a mispredict. Optional counters: BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int DEPTH       = 4,
  parameter int RECOVER_CYC = 3,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       upd_valid,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     pending,
  output logic [CNT_W-1:0]           branch_cnt,
  output logic [CNT_W-1:0]           miss_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  state_t          state;
  logic [RW-1:0]   rec_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     occ;
  logic            mem [DEPTH];

  logic            push_p0;
  logic            pop_p0;
  logic            miss_p0;
  logic            upd_vld_p1;
  logic            upd_taken_p1;
  logic            miss_p1;
  logic            underflow_q;

  // Stage 0: queue handshake and compare against the oldest prediction
  assign pred_ready = (state == RUN) && (occ != (AW+1)'(DEPTH));
  assign push_p0    = pred_valid && pred_ready;
  assign pop_p0     = res_valid && (occ != '0);
  assign miss_p0    = pop_p0 && (mem[rd_ptr] != res_taken);

  always_ff @(posedge clk) begin
    if (push_p0 && !miss_p0)
      mem[wr_ptr] <= pred_taken;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (miss_p0) begin
      // Everything younger than a wrong prediction is on the wrong path, including a same-cycle push
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_p0)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_p0)
        rd_ptr <= rd_ptr + AW'(1);
      if (push_p0 && !pop_p0)
        occ <= occ + (AW+1)'(1);
      else if (pop_p0 && !push_p0)
        occ <= occ - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      rec_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (miss_p0) begin
            state   <= RECOVER;
            rec_cnt <= RW'(RECOVER_CYC - 1);
          end
        end
        RECOVER: begin
          if (rec_cnt == '0)
            state <= RUN;
          else
            rec_cnt <= rec_cnt - RW'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  // Stage 1: registered update strobe, mispredict pulse and sticky underflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_vld_p1   <= 1'b0;
      upd_taken_p1 <= 1'b0;
      miss_p1      <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      upd_vld_p1   <= pop_p0;
      upd_taken_p1 <= pop_p0 && res_taken;
      miss_p1      <= miss_p0;
      if (res_valid && (occ == '0))
        underflow_q <= 1'b1;
    end
  end

  assign upd_valid  = upd_vld_p1;
  assign upd_taken  = upd_taken_p1;
  assign mispredict = miss_p1;
  assign underflow  = underflow_q;
  assign pending    = occ;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (pop_p0 && (branch_cnt_q != '1))
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (miss_p0 && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;
`else
  assign branch_cnt = '0;
  assign miss_cnt   = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (DEPTH=4, RECOVER_CYC=3, CNT_W=2).
module tb_branch_resolver;

  localparam int DEPTH       = 4;
  localparam int RECOVER_CYC = 3;
  localparam int CNT_W       = 2;
`ifdef BRANCH_RESOLVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             pred_valid;
  logic             pred_taken;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic             upd_valid;
  logic             upd_taken;
  logic             mispredict;
  logic             underflow;
  logic [2:0]       pending;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolver #(
    .DEPTH(DEPTH), .RECOVER_CYC(RECOVER_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .mispredict(mispredict),
    .underflow(underflow), .pending(pending),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic drive(input bit pv, input bit pt, input bit rv, input bit rt);
    pred_valid = pv;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_ready", pred_ready, 1);
    chk("rst_pending", pending, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_taken", upd_taken, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);

    // Push T,T,N then resolve T,T,N: all correct
    drive(1, 1, 0, 0); step();
    drive(1, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    chk("s1_pending3", pending, 3);
    drive(0, 0, 1, 1); step();
    chk("s1_upd0_valid", upd_valid, 1);
    chk("s1_upd0_taken", upd_taken, 1);
    chk("s1_upd0_miss", mispredict, 0);
    chk("s1_pending2", pending, 2);
    drive(0, 0, 1, 1); step();
    chk("s1_upd1_valid", upd_valid, 1);
    chk("s1_upd1_taken", upd_taken, 1);
    chk("s1_upd1_miss", mispredict, 0);
    drive(0, 0, 1, 0); step();
    chk("s1_upd2_valid", upd_valid, 1);
    chk("s1_upd2_taken", upd_taken, 0);
    chk("s1_upd2_miss", mispredict, 0);
    chk("s1_pending0", pending, 0);
    drive(0, 0, 0, 0); step();
    chk("s1_upd_idle", upd_valid, 0);
    chk("s1_branch_cnt", branch_cnt, STATS ? 3 : 0);
    chk("s1_miss_cnt", miss_cnt, 0);

    // Fill queue: T,N,T,N
    do_reset();
    drive(1, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    drive(1, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    chk("s2_pending4", pending, 4);
    chk("s2_full_ready", pred_ready, 0);
    drive(1, 1, 0, 0); step();
    chk("s2_fifth_ignored", pending, 4);
    // Pop oldest (T) while fetch still asserts valid: no push while full
    drive(1, 1, 1, 1);
    #1;
    chk("s2_ready_low_on_pop", pred_ready, 0);
    step();
    chk("s2_pending_after_pop", pending, 3);
    chk("s2_ready_reopen", pred_ready, 1);
    chk("s2_pop_miss", mispredict, 0);
    // Push and correct pop (entry N) together
    drive(1, 0, 1, 0); step();
    chk("s2_pushpop_pending", pending, 3);
    chk("s2_pushpop_upd_valid", upd_valid, 1);
    chk("s2_pushpop_upd_taken", upd_taken, 0);
    chk("s2_pushpop_miss", mispredict, 0);
    // Remaining order: T, N, N
    drive(0, 0, 1, 1); step();
    chk("s2_drain0_miss", mispredict, 0);
    drive(0, 0, 1, 0); step();
    chk("s2_drain1_miss", mispredict, 0);
    drive(0, 0, 1, 0); step();
    chk("s2_drain2_miss", mispredict, 0);
    chk("s2_drain_pending", pending, 0);
    drive(0, 0, 0, 0);

    // Mispredict with a same-cycle push
    do_reset();
    drive(1, 1, 0, 0); step();
    drive(1, 1, 0, 0); step();
    drive(1, 1, 0, 0); step();
    drive(1, 1, 1, 0);
    #1;
    chk("s3_ready_pre", pred_ready, 1);
    step();
    chk("s3_mispredict", mispredict, 1);
    chk("s3_upd_valid", upd_valid, 1);
    chk("s3_upd_taken", upd_taken, 0);
    chk("s3_pending_flushed", pending, 0);
    chk("s3_recover0_ready", pred_ready, 0);
    drive(0, 0, 0, 0); step();
    chk("s3_miss_one_cycle", mispredict, 0);
    chk("s3_recover1_ready", pred_ready, 0);
    step();
    chk("s3_recover2_ready", pred_ready, 0);
    step();
    chk("s3_run_ready", pred_ready, 1);
    chk("s3_pending_final", pending, 0);
    chk("s3_miss_cnt", miss_cnt, STATS ? 1 : 0);
    chk("s3_underflow", underflow, 0);

    // Underflow is sticky and cleared only by reset
    do_reset();
    drive(0, 0, 1, 1); step();
    chk("s5_underflow_set", underflow, 1);
    chk("s5_no_upd", upd_valid, 0);
    chk("s5_no_branch", branch_cnt, 0);
    drive(0, 0, 0, 0); step();
    step();
    chk("s5_underflow_sticky", underflow, 1);
    reset = 1'b0;
    #1;
    chk("s5_underflow_async_clr", underflow, 0);
    reset = 1'b1;

    // Counter saturation: five mispredicting branches
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0); step();
      drive(0, 0, 1, 0); step();
      chk("s6_miss_pulse", mispredict, 1);
      drive(0, 0, 0, 0);
      step(); step(); step();
      chk("s6_ready_back", pred_ready, 1);
    end
    chk("s6_miss_sat", miss_cnt, STATS ? 3 : 0);
    chk("s6_branch_sat", branch_cnt, STATS ? 3 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
